fetch_queue: RTL
================

# fetch_queue

Instruction fetch front end that produces the `op`/`funct3`/`funct7` fields the main decoder consumes, and reacts to the decoder's `pause` and the pipeline's redirect. It fetches sequentially from instruction memory and buffers words with their PCs in a small FIFO. It presents the FIFO head to decode through a valid/ready handshake. It sits between instruction memory and the decode stage.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  32  word address of the request (`pc`).
- `imem_rdata`  in  32  instruction word; valid exactly one cycle after `imem_req`; never stalls.
- `redirect`  in  1  taken jump/branch resolved; flush and refetch.
- `redirect_pc`  in  32  redirect target.
- `pause`  in  1  decoder pause for the head instruction (EBREAK/ECALL/FENCE class).
- `resume`  in  1  leave halted state.
- `dec_valid`  out  1  head entry valid.
- `dec_ready`  in  1  decode accepts head.
- `dec_instr`  out  32  head instruction; 32'h0000_0013 (NOP) when `dec_valid`=0.
- `dec_pc`  out  32  head PC; 0 when `dec_valid`=0.
- `op`  out  7  `dec_instr[6:0]`.
- `funct3`  out  3  `dec_instr[14:12]`.
- `funct7`  out  7  `dec_instr[31:25]`.
- `halted`  out  1  state is HALTED.
- `misalign`  out  1  sticky misaligned-redirect flag (0 when macro absent).

## Operation
- States: RUN, HALTED. Reset → RUN.
- Occupancy accounting: `count` (FIFO entries) plus `inflight` (0/1, request issued last cycle). `imem_req` = RUN && !redirect && (count + inflight < DEPTH) && !(handshake with pause).
- On request: `pc` ← `pc + 4` (32-bit wraparound at 32'hFFFF_FFFC → 0). The response is written to the tail with its PC the next cycle, unless killed.
- Handshake: `dec_valid && dec_ready` pops the head. Push and pop in the same cycle are allowed at any occupancy, including full.
- Redirect (any state): flush the FIFO, kill the in-flight response, and set `pc` ← `redirect_pc`. In RUN, the request for the target issues the next cycle. In HALTED, only `pc` updates.
- Pause: sampled only on a handshake cycle. The popped instruction is delivered, then the state → HALTED, the remaining FIFO and in-flight response are flushed, and `pc` ← popped PC + 4.
- Priority within one cycle: reset > redirect > pause > resume. If redirect and pause coincide, redirect wins and the state stays RUN.
- HALTED: no requests, `dec_valid`=0. `resume` → RUN, and fetch restarts from `pc` the next cycle. `resume` in RUN is ignored.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `dec_valid`=0, `dec_instr`=32'h13, `dec_pc`=0, `halted`=0, `misalign`=0, FIFO empty, `inflight`=0.
- First request on the cycle after `reset` deasserts (cycle N). `imem_rdata` arrives at N+1, and `dec_valid` rises at N+2 (registered FIFO, no bypass).
- Steady state: one instruction per cycle while `dec_ready`=1.
- Redirect at cycle N: `dec_valid`=0 from N+1. The request for the target issues at N+1, and its head is valid at N+3.
- Pause handshake at N: `halted`=1 and `dec_valid`=0 from N+1. `resume` at M: request at M+1, `dec_valid` at M+3.
- Full FIFO with `dec_ready`=0: requests stop, nothing is dropped, and outputs hold stable.
- Reset mid-operation: returns to reset values in one cycle. A response arriving after reset is discarded.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: a redirect with `redirect_pc[1:0]` ≠ 0 sets `misalign` (sticky until reset) and forces HALTED. In that state `resume` is ignored and no requests issue.
- Undefined: `redirect_pc[1:0]` is silently forced to 0, and `misalign` is tied 0.

## Test plan
- Reset with `RESET_PC`=32'h100, memory holding ADDI words, `dec_ready`=1: requests to 0x100, 0x104, … with no gaps; first `dec_valid` two cycles after the first request, `dec_pc`=0x100, `op`=7'h13.
- Hold `dec_ready`=0 for 10 cycles: exactly `DEPTH`=4 requests, then `imem_req`=0. Release: PCs 0x100–0x10C are delivered in order, then fetching resumes at 0x110.
- Redirect to 0x200 while 3 entries are queued and one is in flight: `dec_valid`=0 next cycle, the killed response is never presented, and the next delivered `dec_pc`=0x200.
- Head = 32'h0010_0073 (EBREAK) at 0x120 with `pause`=1 on handshake: `halted`=1, no requests. `resume` pulse leads to a request at 0x124.
- Redirect and pause asserted in the same cycle to 0x300: `halted` stays 0 and the next `dec_pc`=0x300.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x302: `misalign`=1, `halted`=1, and a subsequent `resume` is ignored. Without the macro: fetch resumes at 0x300.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch into a PC-tagged FIFO feeding decode via valid/ready.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets set a sticky flag and halt fetch.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        pause,
  input  logic        resume,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        halted,
  output logic        misalign
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop      = 32'h0000_0013;
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(DEPTH);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e          r_state, w_state_d;
  logic [31:0]     r_pc, w_pc_d;
  logic            r_inflight;
  logic [31:0]     r_inflight_pc;
  logic [PtrW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0] r_count, w_count_d;
  logic [31:0]     r_instr_mem [DEPTH];
  logic [31:0]     r_pc_mem    [DEPTH];

  logic            w_pop, w_pause_hs, w_push, w_flush, w_bad_target;
  logic [31:0]     w_target;
  logic [CntW:0]   w_occupancy;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_target     = redirect_pc;
  assign w_bad_target = redirect_pc[1:0] != 2'b00;
  assign misalign     = r_misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (redirect && w_bad_target) begin
      r_misalign <= 1'b1;
    end
  end
`else
  assign w_target     = redirect_pc & 32'hFFFF_FFFC;
  assign w_bad_target = 1'b0;
  assign misalign     = 1'b0;
`endif

  assign dec_valid  = (r_state == StRun) && (r_count != '0);
  assign dec_instr  = dec_valid ? r_instr_mem[r_rd_ptr] : Nop;
  assign dec_pc     = dec_valid ? r_pc_mem[r_rd_ptr] : 32'h0;
  assign op         = dec_instr[6:0];
  assign funct3     = dec_instr[14:12];
  assign funct7     = dec_instr[31:25];
  assign halted     = (r_state == StHalted);
  assign imem_addr  = r_pc;

  assign w_pop       = dec_valid && dec_ready;
  assign w_pause_hs  = w_pop && pause;
  // A response still lands unless this cycle flushes the queue.
  assign w_push      = r_inflight && !redirect && !w_pause_hs;
  assign w_occupancy = {1'b0, r_count} + {{CntW{1'b0}}, r_inflight};
  assign imem_req    = !reset && (r_state == StRun) && !redirect &&
                       (w_occupancy < DepthCnt) && !w_pause_hs;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_flush   = 1'b0;
    if (redirect) begin
      w_flush = 1'b1;
      w_pc_d  = w_target;
      if (w_bad_target) begin
        w_state_d = StHalted;
      end
    end else if (w_pause_hs) begin
      w_flush   = 1'b1;
      w_pc_d    = dec_pc + 32'd4;
      w_state_d = StHalted;
    end else if (r_state == StHalted) begin
      if (resume && !misalign) begin
        w_state_d = StRun;
      end
    end else if (imem_req) begin
      w_pc_d = r_pc + 32'd4;
    end
  end

  always_comb begin
    w_count_d = r_count;
    if (w_flush) begin
      w_count_d = '0;
    end else if (w_push && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StRun;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_inflight <= imem_req;
      if (imem_req) begin
        r_inflight_pc <= r_pc;
      end
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PtrW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end
      end
      r_count <= w_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
    end
  end

endmodule
